mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache refill path (I side) and the data path (D side).
- I side issues block reads on an I-cache miss; the pipeline's PC is held while `hit` is low.
- D side issues block reads or single-word write-through writes.
- The block runs a burst FSM with a word counter, latches the request address, and returns per-word valid strobes and a one-cycle done pulse to the owning requester.

Parameters:
- BLOCK_WORDS, 4, words per refill burst; power of two, ≥2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock
- rst_b  in  1  reset, asynchronous, active-low
- i_req  in  1  I-side block-read request; held until i_done
- i_addr  in  ADDR_W  I-side byte address; low log2(BLOCK_WORDS)+2 bits ignored
- d_req  in  1  D-side request; held until d_done
- d_we  in  1  D-side 1 = single-word write, 0 = block read
- d_addr  in  ADDR_W  D-side byte address
- d_wdata  in  32  D-side write data
- i_gnt  out  1  I side owns memory (burst in progress)
- d_gnt  out  1  D side owns memory
- word_valid_i  out  1  rdata is valid for I side this cycle
- word_valid_d  out  1  rdata is valid for D side this cycle
- word_idx  out  log2(BLOCK_WORDS)  index of the word currently on rdata
- rdata  out  32  read data, passed through from mem_rdata
- i_done  out  1  one-cycle pulse, I burst complete
- d_done  out  1  one-cycle pulse, D access complete
- mem_addr  out  ADDR_W  memory word address
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completes the current word this cycle

Behaviour:
- **States:** IDLE, I_RD, D_RD, D_WR, DONE.
- **Reset (async, rst_b=0):**
  - State goes to IDLE; counter, latched address and last_owner are cleared.
  - All outputs are 0: gnt, word_valid, done, mem_read, mem_write, mem_addr, mem_wdata, word_idx.
  - Reset asserted mid-burst aborts the burst immediately with no done pulse.
- **IDLE:** requests are sampled at the clock edge.
  - d_req wins over i_req (fixed priority, see Optional Feature).
  - On grant: latch the block base address (word-aligned for D_WR), latch d_wdata on D_WR, clear the counter.
  - Next state is I_RD, D_RD or D_WR; the grant takes one cycle from req to state entry.
- **I_RD / D_RD:**
  - mem_read=1 and the matching gnt=1.
  - mem_addr = {base[ADDR_W-1:log2(BLOCK_WORDS)+2], cnt, 2'b00}.
  - Each cycle with mem_ready=1: the owner's word_valid=1, word_idx=cnt, rdata=mem_rdata (combinational), and cnt increments.
  - mem_ready=0 holds everything, including address and cnt; wait states are unbounded.
  - On mem_ready with cnt==BLOCK_WORDS-1, go to DONE; cnt wraps to 0.
- **D_WR:**
  - mem_write=1, mem_wdata = latched data, mem_addr = latched word address, d_gnt=1.
  - mem_ready goes to DONE.
- **DONE (exactly one cycle):**
  - i_done or d_done = 1 for the finished owner; gnt, mem_read and mem_write are 0.
  - The requester deasserts req at the edge leaving DONE.
  - Next state is IDLE, which always lasts at least one cycle, so a held req is never double-served.
- **Mid-burst request changes:** changes on req, addr or wdata during a transfer are ignored. A dropped req still completes the burst and still receives done.
- **mem_read / mem_write:** never both high. Both are 0 in IDLE and DONE.
- **last_owner:** updated on DONE; used only by the optional feature.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- **Defined:** when both requests are present in IDLE, grant the side that is not last_owner. last_owner resets to I, so D wins the first conflict. A single requester is always granted.
- **Undefined:** fixed priority, D over I. last_owner may be removed.

Test Plan:
- **I-only burst:** i_req=1, i_addr=0x0000_1234, mem_ready=1 every cycle.
  - i_gnt rises 1 cycle later.
  - mem_addr steps 0x1230, 0x1234, 0x1238, 0x123C.
  - word_valid_i with word_idx 0..3, then i_done for 1 cycle, then i_gnt=0.
- **D write:** d_req=1, d_we=1, d_addr=0x0000_0104, d_wdata=0xDEADBEEF, mem_ready after 3 wait cycles.
  - mem_write=1 held 4 cycles at 0x104 with data 0xDEADBEEF.
  - d_done for 1 cycle; word_valid_d never asserted.
- **Conflict:** i_req and d_req rise in the same cycle.
  - D_RD burst runs first (0x2000–0x200C), then d_done, one IDLE cycle, then the I burst.
  - With MEM_ARB_ROUND_ROBIN_EN, a second simultaneous conflict is granted to I.
- **Wait states:** mem_ready pattern 1,0,0,1,1,0,1.
  - Exactly 4 word_valid pulses, word_idx 0,1,2,3.
  - mem_addr stable during the 0 cycles.
- **Reset mid-burst:** rst_b=0 after word 1 of an I burst.
  - mem_read, i_gnt and i_done drop to 0 immediately.
  - After release with i_req held, a fresh burst restarts at word_idx 0.
- **Address change mid-burst:** i_addr changes to 0x5000 during a burst from 0x1230.
  - Remaining mem_addr values stay in the 0x1230 block.

Source files
------------

// File: rtl/mem_arbiter.sv
// Main-memory arbiter between I-cache refill and D-side reads/writes.
// Optional round-robin on conflicts: define MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32,
  localparam int CW         = $clog2(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              i_gnt,
  output logic              d_gnt,
  output logic              word_valid_i,
  output logic              word_valid_d,
  output logic [CW-1:0]     word_idx,
  output logic [31:0]       rdata,
  output logic              i_done,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int OFF = CW + 2;

  typedef enum logic [2:0] {
    IDLE, I_RD, D_RD, D_WR, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic              pick_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = D side finished last; reset to I so D wins the first conflict
  logic last_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      last_q <= 1'b0;
    end else if (state_q == DONE) begin
      last_q <= owner_q;
    end
  end

  assign pick_d = d_req && !(i_req && last_q);
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    word_valid_i = 1'b0;
    word_valid_d = 1'b0;
    word_idx     = cnt_q;
    rdata        = '0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_addr     = '0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_wdata    = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          owner_d = 1'b1;
          cnt_d   = '0;
          if (d_we) begin
            state_d = D_WR;
            base_d  = {d_addr[ADDR_W-1:2], 2'b00};
            wdata_d = d_wdata;
          end else begin
            state_d = D_RD;
            base_d  = d_addr;
          end
        end else if (i_req) begin
          owner_d = 1'b0;
          cnt_d   = '0;
          state_d = I_RD;
          base_d  = i_addr;
        end
      end
      I_RD, D_RD: begin
        mem_read = 1'b1;
        i_gnt    = (state_q == I_RD);
        d_gnt    = (state_q == D_RD);
        mem_addr = {base_q[ADDR_W-1:OFF], cnt_q, 2'b00};
        if (mem_ready) begin
          word_valid_i = (state_q == I_RD);
          word_valid_d = (state_q == D_RD);
          rdata        = mem_rdata;
          cnt_d        = cnt_q + CW'(1);
          if (cnt_q == CW'(BLOCK_WORDS - 1)) begin
            state_d = DONE;
          end
        end
      end
      D_WR: begin
        mem_write = 1'b1;
        d_gnt     = 1'b1;
        mem_addr  = base_q;
        mem_wdata = wdata_q;
        if (mem_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        i_done  = !owner_q;
        d_done  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
